lidar_serial_motor_io: RTL and testbench



---
 rtl/lidar_serial_motor_io.sv | 246 ++++++++++++++++++++++++
 tb/tb_lidar_serial_motor_io.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lidar_serial_motor_io.sv
// -----------------------------------------------------------------------------
// lidar_serial_motor_io
//
// Physical-layer I/O for the RPLIDAR link: an 8N1 UART receiver, an 8N1 UART
// transmitter and a fixed-frequency motor PWM generator. All three share one
// clock and one reset. The block sits between the board pins and the
// command/packet parsing logic.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-high reset
//   rx_serial   in   1  UART line from the lidar (asynchronous, idles high)
//   rx_data     out  8  last good received byte
//   rx_valid    out  1  one-cycle pulse, rx_data holds a new byte
//   rx_error    out  1  one-cycle pulse, framing error (stop bit low)
//   tx_data     in   8  byte to send, sampled together with tx_start
//   tx_start    in   1  send request, accepted only while tx_busy is low
//   tx_serial   out  1  UART line to the lidar (idles high)
//   tx_busy     out  1  high while a frame is on the line
//   pwm_en      in   1  low holds the PWM counter at 0 and forces pwm_out low
//   duty_cycle  in   8  PWM duty in 1/256 steps
//   pwm_out     out  1  registered motor PWM
// -----------------------------------------------------------------------------
module lidar_serial_motor_io #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int PWM_FREQ  = 20000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_error,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_serial,
   output logic       tx_busy,
   input  logic       pwm_en,
   input  logic [7:0] duty_cycle,
   output logic       pwm_out
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int BAUD_CNT_W   = $clog2(CLKS_PER_BIT);
   localparam int PERIOD       = CLK_FREQ / PWM_FREQ;
   localparam int PWM_CNT_W    = $clog2(PERIOD);
   localparam int PROD_W       = PWM_CNT_W + 8;

   localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PWM_CNT_W-1:0]  PWM_LAST  = PWM_CNT_W'(PERIOD - 1);

   // ---------------------------------------------------------------------------
   // UART receiver
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   rx_state_t                rx_state, rx_state_nxt;
   logic                     rx_meta, rx_sync, rx_prev;
   logic [BAUD_CNT_W-1:0]    rx_cnt;
   logic [2:0]               rx_bit_idx;
   logic [7:0]               rx_shift;
   logic                     rx_half_done, rx_bit_done;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   // The line idles high, so all three come out of reset high.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours; blocking here would collapse the
   // synchroniser chain into a single flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_serial;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_half_done = (rx_cnt == HALF_LAST);
   assign rx_bit_done  = (rx_cnt == BIT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_state_nxt;
   end

   // NOTE: the next-state value is given a default before the case so that
   // every path assigns it; a missing branch would otherwise infer a latch.
   always_comb begin
      rx_state_nxt = rx_state;
      case (rx_state)
         RX_IDLE:      if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
         // Half a bit after the edge the line must still be low, else glitch.
         RX_START:     if (rx_half_done) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:      if (rx_bit_done && rx_bit_idx == 3'd7) rx_state_nxt = RX_STOP;
         RX_STOP:      if (rx_bit_done) rx_state_nxt = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
         RX_WAIT_HIGH: if (rx_sync) rx_state_nxt = RX_IDLE;
         default:      rx_state_nxt = RX_IDLE;
      endcase
   end

   // Bit timer restarts on every state change and after each data sample, so
   // every sample after the start check lands one full bit later (mid-bit).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_cnt     <= '0;
         rx_bit_idx <= '0;
         rx_shift   <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_error   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_error <= 1'b0;

         if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH ||
             rx_state_nxt != rx_state || rx_bit_done)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;

         if (rx_state == RX_START)
            rx_bit_idx <= '0;

         if (rx_state == RX_DATA && rx_bit_done) begin
            rx_shift   <= {rx_sync, rx_shift[7:1]};
            rx_bit_idx <= rx_bit_idx + 1'b1;
         end

         if (rx_state == RX_STOP && rx_bit_done) begin
            if (rx_sync) begin
               rx_data  <= rx_shift;
               rx_valid <= 1'b1;
            end else begin
               rx_error <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // UART transmitter
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   tx_state_t             tx_state, tx_state_nxt;
   logic [BAUD_CNT_W-1:0] tx_cnt;
   logic [2:0]            tx_bit_idx;
   logic [7:0]            tx_shift;
   logic                  tx_bit_done;

   assign tx_bit_done = (tx_cnt == BIT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_state_nxt;
   end

   always_comb begin
      tx_state_nxt = tx_state;
      case (tx_state)
         TX_IDLE:  if (tx_start) tx_state_nxt = TX_START;
         TX_START: if (tx_bit_done) tx_state_nxt = TX_DATA;
         TX_DATA:  if (tx_bit_done && tx_bit_idx == 3'd7) tx_state_nxt = TX_STOP;
         TX_STOP:  if (tx_bit_done) tx_state_nxt = TX_IDLE;
         default:  tx_state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_cnt     <= '0;
         tx_bit_idx <= '0;
         tx_shift   <= '0;
      end else if (tx_state == TX_IDLE) begin
         tx_cnt     <= '0;
         tx_bit_idx <= '0;
         if (tx_start) tx_shift <= tx_data;
      end else begin
         tx_cnt <= tx_bit_done ? '0 : tx_cnt + 1'b1;
         if (tx_state == TX_DATA && tx_bit_done)
            tx_bit_idx <= tx_bit_idx + 1'b1;
      end
   end

   // Line level is a pure decode of registered state, so it changes exactly on
   // the state/bit-index edges and returns high at once on reset.
   always_comb begin
      tx_serial = 1'b1;
      case (tx_state)
         TX_START: tx_serial = 1'b0;
         TX_DATA:  tx_serial = tx_shift[tx_bit_idx];
         default:  tx_serial = 1'b1;
      endcase
   end

   assign tx_busy = (tx_state != TX_IDLE);

   // ---------------------------------------------------------------------------
   // Motor PWM
   // ---------------------------------------------------------------------------
   logic [PWM_CNT_W-1:0] pwm_cnt;
   logic [PWM_CNT_W-1:0] pwm_thresh;
   logic [PWM_CNT_W-1:0] thresh_new;
   logic [PWM_CNT_W-1:0] thresh_eff;
   logic [PROD_W-1:0]    duty_prod;

   // Full-width product first, then drop the 1/256 scaling.
   assign duty_prod  = PROD_W'(duty_cycle) * PROD_W'(PERIOD);
   assign thresh_new = PWM_CNT_W'(duty_prod >> 8);

   // At count 0 the freshly latched threshold already governs the compare,
   // so a period never mixes the old and new duty.
   assign thresh_eff = (pwm_cnt == '0) ? thresh_new : pwm_thresh;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt    <= '0;
         pwm_thresh <= '0;
         pwm_out    <= 1'b0;
      end else if (!pwm_en) begin
         pwm_cnt <= '0;
         pwm_out <= 1'b0;
      end else begin
         if (pwm_cnt == '0) pwm_thresh <= thresh_new;
         pwm_out <= (pwm_cnt < thresh_eff);
         pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_lidar_serial_motor_io.sv
// -----------------------------------------------------------------------------
// tb_lidar_serial_motor_io
//
// Directed bench for lidar_serial_motor_io at the default 100 MHz / 115200 /
// 20 kHz settings. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_lidar_serial_motor_io;

   localparam int CPB = 868;

   logic       clk;
   logic       reset;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_serial;
   logic       tx_busy;
   logic       pwm_en;
   logic [7:0] duty_cycle;
   logic       pwm_out;

   int n_checks = 0;
   int n_errors = 0;

   // Receive-side event counters, updated every falling edge.
   int         valid_cnt = 0;
   int         error_cnt = 0;
   int         both_cnt  = 0;
   logic [7:0] last_rx   = 8'h00;

   lidar_serial_motor_io dut (
      .clk        (clk),
      .reset      (reset),
      .rx_serial  (rx_serial),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_error   (rx_error),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_serial  (tx_serial),
      .tx_busy    (tx_busy),
      .pwm_en     (pwm_en),
      .duty_cycle (duty_cycle),
      .pwm_out    (pwm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt = valid_cnt + 1;
         last_rx   = rx_data;
      end
      if (rx_error) error_cnt = error_cnt + 1;
      if (rx_valid && rx_error) both_cnt = both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks = n_checks + 1;
      if (actual !== expected) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at the first cycle of a start bit; returns at the first cycle after
   // the stop bit. Checks each bit at its first and last cycle.
   task automatic tx_expect_frame(input logic [7:0] b, input string tag,
                                  input bit poke);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         check($sformatf("%s bit%0d first", tag, i), 32'(tx_serial), 32'(frame[i]));
         check($sformatf("%s busy bit%0d", tag, i), 32'(tx_busy), 32'd1);
         if (poke && i == 3) begin
            wait_cycles(100);
            tx_data  = 8'hFF;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            wait_cycles(CPB - 102);
         end else begin
            wait_cycles(CPB - 1);
         end
         check($sformatf("%s bit%0d last", tag, i), 32'(tx_serial), 32'(frame[i]));
         wait_cycles(1);
      end
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      rx_serial = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         wait_cycles(CPB);
      end
      rx_serial = stop_bit;
      wait_cycles(CPB);
   endtask

   initial begin
      int highs;

      reset      = 1'b1;
      rx_serial  = 1'b1;
      tx_data    = 8'h00;
      tx_start   = 1'b0;
      pwm_en     = 1'b0;
      duty_cycle = 8'h00;

      // ---------------- reset values ----------------
      wait_cycles(3);
      check("rst rx_data",   32'(rx_data),   32'h00);
      check("rst rx_valid",  32'(rx_valid),  32'd0);
      check("rst rx_error",  32'(rx_error),  32'd0);
      check("rst tx_serial", 32'(tx_serial), 32'd1);
      check("rst tx_busy",   32'(tx_busy),   32'd0);
      check("rst pwm_out",   32'(pwm_out),   32'd0);
      reset = 1'b0;
      wait_cycles(5);

      // ---------------- async reset mid-frame ----------------
      pwm_en     = 1'b1;
      duty_cycle = 8'd255;
      tx_data    = 8'h5A;
      tx_start   = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      wait_cycles(2000);
      check("pre-rst tx_busy", 32'(tx_busy), 32'd1);
      check("pre-rst pwm_out", 32'(pwm_out), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async rst tx_serial", 32'(tx_serial), 32'd1);
      check("async rst tx_busy",   32'(tx_busy),   32'd0);
      check("async rst pwm_out",   32'(pwm_out),   32'd0);
      check("async rst rx_valid",  32'(rx_valid),  32'd0);
      @(negedge clk);
      reset  = 1'b0;
      pwm_en = 1'b0;
      wait_cycles(5);
      check("post-rst tx_busy",   32'(tx_busy),   32'd0);
      check("post-rst tx_serial", 32'(tx_serial), 32'd1);

      // ---------------- TX 0xA5, ignored restart, back-to-back 0x20 ----------------
      tx_data  = 8'hA5;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = 8'h00;
      tx_expect_frame(8'hA5, "tx_a5", 1'b1);
      check("tx_a5 idle busy",   32'(tx_busy),   32'd0);
      check("tx_a5 idle serial", 32'(tx_serial), 32'd1);
      tx_data  = 8'h20;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_expect_frame(8'h20, "tx_20", 1'b0);
      check("tx_20 idle busy", 32'(tx_busy), 32'd0);

      // ---------------- RX 0x20 then 0x55 back-to-back ----------------
      rx_send(8'h20, 1'b1);
      check("rx_20 valid count", 32'(valid_cnt), 32'd1);
      check("rx_20 data",        32'(last_rx),   32'h20);
      check("rx_20 error count", 32'(error_cnt), 32'd0);
      rx_send(8'h55, 1'b1);
      wait_cycles(50);
      check("rx_55 valid count", 32'(valid_cnt), 32'd2);
      check("rx_55 data",        32'(last_rx),   32'h55);
      check("rx_55 rx_data",     32'(rx_data),   32'h55);
      check("rx_55 error count", 32'(error_cnt), 32'd0);

      // ---------------- framing error, then recovery ----------------
      rx_send(8'h3C, 1'b0);
      wait_cycles(2000);
      check("rx_ferr error count", 32'(error_cnt), 32'd1);
      check("rx_ferr valid count", 32'(valid_cnt), 32'd2);
      check("rx_ferr rx_data",     32'(rx_data),   32'h55);
      rx_serial = 1'b1;
      wait_cycles(50);
      rx_send(8'h3C, 1'b1);
      wait_cycles(50);
      check("rx_recover valid count", 32'(valid_cnt), 32'd3);
      check("rx_recover data",        32'(last_rx),   32'h3C);
      check("rx_recover error count", 32'(error_cnt), 32'd1);

      // ---------------- 100-cycle glitch ----------------
      rx_serial = 1'b0;
      wait_cycles(100);
      rx_serial = 1'b1;
      wait_cycles(2000);
      check("rx_glitch valid count", 32'(valid_cnt), 32'd3);
      check("rx_glitch error count", 32'(error_cnt), 32'd1);
      check("rx valid&error overlap", 32'(both_cnt), 32'd0);

      // ---------------- PWM duty 230, mid-period change to 0 ----------------
      duty_cycle = 8'd230;
      pwm_en     = 1'b1;
      highs      = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (pwm_out) highs++;
         if (i == 0)    check("pwm230 first high", 32'(pwm_out), 32'd1);
         if (i == 4491) check("pwm230 last high",  32'(pwm_out), 32'd1);
         if (i == 4492) check("pwm230 first low",  32'(pwm_out), 32'd0);
         if (i == 1000) duty_cycle = 8'd0;
      end
      check("pwm230 high cycles", 32'(highs), 32'd4492);

      highs = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (pwm_out) highs++;
      end
      check("pwm0 high cycles", 32'(highs), 32'd0);

      // ---------------- PWM duty 255 from re-enable, then disable ----------------
      pwm_en     = 1'b0;
      duty_cycle = 8'd255;
      wait_cycles(2);
      check("pwm disabled low", 32'(pwm_out), 32'd0);
      pwm_en = 1'b1;
      highs  = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (pwm_out) highs++;
      end
      check("pwm255 high cycles", 32'(highs), 32'd4980);
      wait_cycles(10);
      check("pwm255 next period high", 32'(pwm_out), 32'd1);
      pwm_en = 1'b0;
      @(negedge clk);
      check("pwm_en=0 low in 1 cycle", 32'(pwm_out), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
